uart_tx_arbiter: RTL and testbench

//  Shares one RS-232 transmitter between NUM_REQ byte-stream requesters; round-robin arbitration, message lock.

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types for the UART TX arbiter.
// FSM state encoding, transmitter done code, clog2 helper.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_REL,
    ST_GAP
  } state_t;

  localparam logic [4:0] TX_DONE_STATE = 5'h10;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports: i_valid (N requests), i_ptr (first index to try),
//        o_grant (one-hot winner, 0 if none), o_idx (winner index).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic w_found;

  // Walk k = 0..N-1 from the pointer; first valid slot wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_valid[j] &&
            ((int'(i_ptr) + k) % N) == j) begin
          w_found    = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte
// streams with round-robin grant and a per-message lock.
// Ports: clk, reset_n (sync, active-low); req_valid/req_data/req_last
//   in, req_ready out (one-hot pulse); tx_start/tx_data out, tx_busy/
//   tx_state in; grant_id (owner), active (lock held), abort (pulse).
// Option: define UART_ARB_WATCHDOG_EN to abort frames that never
//   complete within WDOG_CYCLES clocks of tx_start rising.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int WDOG_CYCLES = 8192
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [8*NUM_REQ-1:0]      req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_busy,
  input  logic [4:0]                tx_state,
  output logic [clog2(NUM_REQ)-1:0] grant_id,
  output logic                      active,
  output logic                      abort
);

  localparam int IW = clog2(NUM_REQ);

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_ptr;
  logic          r_active;
  logic          r_lock_prev;
  logic          r_last;
  logic [7:0]    r_tx_data;
  logic [31:0]   r_gap;

  logic [NUM_REQ-1:0] w_arb_hot;
  logic [IW-1:0]      w_arb_idx;
  logic [NUM_REQ-1:0] w_own_hot;
  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_byte;
  logic               w_elig;
  logic [IW-1:0]      w_ptr_nxt;

  logic w_grant_now;
  logic w_xfer;
  logic w_drop;
  logic w_gap_load;
  logic w_finish;
  logic w_wdog_exp;
  logic w_wdog_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_hot),
    .o_idx   (w_arb_idx)
  );

  always_comb begin
    w_own_hot   = '0;
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_byte  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_grant == IW'(j)) begin
        w_own_hot[j] = 1'b1;
        w_own_valid  = req_valid[j];
        w_own_last   = req_last[j];
        w_own_byte   = req_data[8*j +: 8];
      end
    end
  end

  // While locked only the owner may proceed.
  assign w_elig = r_active ? w_own_valid : (|w_arb_hot);

  assign w_ptr_nxt = (r_grant == IW'(NUM_REQ - 1)) ?
                     '0 : r_grant + IW'(1);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    tx_start    = 1'b0;
    w_grant_now = 1'b0;
    w_xfer      = 1'b0;
    w_drop      = 1'b0;
    w_gap_load  = 1'b0;
    w_finish    = 1'b0;
    w_wdog_hit  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!tx_busy && w_elig) begin
          w_grant_now = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        req_ready = w_own_hot;
        if (w_own_valid) begin
          w_xfer      = 1'b1;
          w_state_nxt = ST_SEND;
        end else begin
          w_drop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        tx_start = 1'b1;
        if (tx_state == TX_DONE_STATE) begin
          w_state_nxt = ST_REL;
        end else if (w_wdog_exp) begin
          w_wdog_hit  = 1'b1;
          w_state_nxt = ST_REL;
        end
      end
      ST_REL: begin
        if (!tx_busy) begin
          if (GAP_CYCLES == 0) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_gap_load  = 1'b1;
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_gap == 32'd0) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant     <= '0;
      r_ptr       <= '0;
      r_active    <= 1'b0;
      r_lock_prev <= 1'b0;
      r_last      <= 1'b0;
      r_tx_data   <= '0;
      r_gap       <= '0;
    end else begin
      if (w_grant_now) begin
        r_lock_prev <= r_active;
        r_active    <= 1'b1;
        if (!r_active) r_grant <= w_arb_idx;
      end
      // Owner withdrew before the byte moved: undo the grant.
      if (w_drop) r_active <= r_lock_prev;
      if (w_xfer) begin
        r_tx_data <= w_own_byte;
        r_last    <= w_own_last;
      end
      if (w_gap_load) begin
        r_gap <= 32'(GAP_CYCLES - 1);
      end else if (r_state == ST_GAP && r_gap != 32'd0) begin
        r_gap <= r_gap - 32'd1;
      end
      if (w_finish && r_last) begin
        r_active <= 1'b0;
        r_ptr    <= w_ptr_nxt;
      end
      // Aborted byte ends the message; marking it last keeps the
      // later finish idempotent.
      if (w_wdog_hit) begin
        r_active <= 1'b0;
        r_ptr    <= w_ptr_nxt;
        r_last   <= 1'b1;
      end
    end
  end

`ifdef UART_ARB_WATCHDOG_EN
  logic [31:0] r_wdog;
  logic        r_abort;

  assign w_wdog_exp = (r_wdog == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wdog  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_wdog_hit;
      if (r_state == ST_SEND) r_wdog <= r_wdog + 32'd1;
      else                    r_wdog <= '0;
    end
  end

  assign abort = r_abort;
`else
  assign w_wdog_exp = 1'b0;
  assign abort      = 1'b0;
`endif

  assign tx_data  = r_tx_data;
  assign grant_id = r_grant;
  assign active   = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter.
// Queue-fed requesters, simple transmitter model, negedge monitor.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int GAP   = 4;
  localparam int WDOG  = 64;
  localparam int FRAME = 10;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [4:0]      tx_state;
  logic [1:0]      grant_id;
  logic            active;
  logic            abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .GAP_CYCLES  (GAP),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_state  (tx_state),
    .grant_id  (grant_id),
    .active    (active),
    .abort     (abort)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [8:0]  sq [NR][$];
  logic [11:0] log_q[$];
  int          rise_q[$];
  int          gap_q[$];
  int          ready_cnt = 0;
  int          fall_err  = 0;
  int          data_err  = 0;
  int          abort_cnt = 0;
  int          abort_cyc = 0;
  logic        abort_act = 1'b0;
  int          fall_cyc  = 0;
  int          t_vrise   = 0;
  bit          hang      = 1'b0;
  bit          drv_man   = 1'b0;
  logic [NR-1:0] man_valid = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: each presents the head of its queue.
  initial begin
    logic [NR-1:0] tk;
    logic [NR-1:0] pv;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    pv        = '0;
    forever begin
      @(negedge clk);
      tk = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (tk[i] === 1'b1 && !drv_man && sq[i].size() > 0)
          void'(sq[i].pop_front());
      end
      for (int i = 0; i < NR; i++) begin
        if (drv_man) begin
          req_valid[i]       = man_valid[i];
          req_data[8*i +: 8] = 8'hEE;
          req_last[i]        = 1'b1;
        end else if (sq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = sq[i][0][7:0];
          req_last[i]        = sq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      if ((req_valid & ~pv) != '0) t_vrise = cyc;
      pv = req_valid;
    end
  end

  // Transmitter: done code after FRAME clocks, busy tail of 2.
  initial begin
    int ph;
    int mc;
    ph       = 0;
    mc       = 0;
    tx_busy  = 1'b0;
    tx_state = 5'h0;
    forever begin
      @(posedge clk);
      #1;
      case (ph)
        0: if (tx_start === 1'b1) begin
          tx_busy  = 1'b1;
          tx_state = 5'h1;
          mc       = 0;
          ph       = 1;
        end
        1: if (tx_start !== 1'b1) begin
          tx_state = 5'h0;
          mc       = 0;
          ph       = 2;
        end else if (!hang) begin
          if (mc >= FRAME - 1) tx_state = 5'h10;
          else begin
            mc       = mc + 1;
            tx_state = 5'(mc);
          end
        end
        default: begin
          mc = mc + 1;
          if (mc >= 2) begin
            tx_busy = 1'b0;
            ph      = 0;
          end
        end
      endcase
    end
  end

  initial begin
    logic p_start;
    logic p_busy;
    logic p_done;
    p_start = 1'b0;
    p_busy  = 1'b0;
    p_done  = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] === 1'b1 && req_valid[i] === 1'b1)
          log_q.push_back({4'(i), req_data[8*i +: 8]});
        if (req_ready[i] === 1'b1) ready_cnt++;
      end
      if (tx_start === 1'b1 && !p_start) begin
        rise_q.push_back(cyc);
        gap_q.push_back(cyc - fall_cyc);
      end
      if (tx_busy === 1'b0 && p_busy) fall_cyc = cyc;
      if (p_done && tx_start !== 1'b0) fall_err++;
      if (tx_start === 1'b1 && log_q.size() > 0 &&
          tx_data !== log_q[$][7:0]) data_err++;
      if (abort === 1'b1) begin
        abort_cnt++;
        abort_cyc = cyc;
        abort_act = active;
      end
      p_start = (tx_start === 1'b1);
      p_busy  = (tx_busy === 1'b1);
      p_done  = (tx_start === 1'b1) && (tx_state == 5'h10);
    end
  end

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("log_timeout", 32'(log_q.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int  k;
    bit  q;
    k = 0;
    q = 1'b0;
    while (!q && k < 3000) begin
      @(negedge clk);
      k++;
      q = (active === 1'b0) && (tx_start === 1'b0) &&
          (tx_busy === 1'b0) && (req_valid == '0);
      for (int i = 0; i < NR; i++) if (sq[i].size() > 0) q = 1'b0;
    end
    if (k >= 3000) check("idle_timeout", 32'(k), 32'd0);
    repeat (GAP + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_start"}, 32'(tx_start), 32'd0);
    check({tag, "_data"},  32'(tx_data), 32'd0);
    check({tag, "_grant"}, 32'(grant_id), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_abort"}, 32'(abort), 32'd0);
  endtask

  initial begin
    int base;
    int rc;
    int nr;
    int mg;
    logic [11:0] exp2 [5];
    logic [11:0] exp3 [4];
    exp2 = '{12'h010, 12'h111, 12'h212, 12'h313, 12'h020};
    exp3 = '{12'h131, 12'h132, 12'h133, 12'h241};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Single byte from requester 0.
    base = log_q.size();
    rc   = ready_cnt;
    nr   = rise_q.size();
    sq[0].push_back(9'h1A5);
    wait_log(base + 1);
    wait_idle();
    check("t1_xfer", 32'(log_q[base]), 32'h0A5);
    check("t1_ready_pulses", 32'(ready_cnt - rc), 32'd1);
    check("t1_latency", 32'(rise_q[nr] - t_vrise), 32'd2);
    check("t1_active", 32'(active), 32'd0);

    // All four valid from pointer 0: 0,1,2,3,0.
    do_reset();
    base = log_q.size();
    rc   = ready_cnt;
    nr   = rise_q.size();
    sq[0].push_back(9'h110);
    sq[0].push_back(9'h120);
    sq[1].push_back(9'h111);
    sq[2].push_back(9'h112);
    sq[3].push_back(9'h113);
    wait_log(base + 5);
    wait_idle();
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_order%0d", i), 32'(log_q[base + i]),
            32'(exp2[i]));
    check("t2_ready_pulses", 32'(ready_cnt - rc), 32'd5);
    check("t2_frames", 32'(rise_q.size() - nr), 32'd5);
    mg = 1000;
    for (int i = 1; i < 5; i++)
      if (gap_q[nr + i] < mg) mg = gap_q[nr + i];
    check("t2_min_gap", 32'(mg), 32'(GAP + 3));

    // Locked 3-byte message from 1 while 2 waits (pointer is 1).
    base = log_q.size();
    sq[1].push_back(9'h031);
    sq[1].push_back(9'h032);
    sq[1].push_back(9'h133);
    sq[2].push_back(9'h141);
    wait_log(base + 4);
    wait_idle();
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_order%0d", i), 32'(log_q[base + i]),
            32'(exp3[i]));

    // Requester 2 withdraws during LOAD: no transfer, lock undone.
    base = log_q.size();
    nr   = rise_q.size();
    @(posedge clk);
    #2;
    drv_man   = 1'b1;
    man_valid = 4'b0100;
    @(posedge clk);
    #2 man_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    check("drop_ready", 32'(req_ready), 32'h4);
    check("drop_active_load", 32'(active), 32'd1);
    repeat (3) @(negedge clk);
    check("drop_active_after", 32'(active), 32'd0);
    check("drop_no_xfer", 32'(log_q.size() - base), 32'd0);
    check("drop_no_frame", 32'(rise_q.size() - nr), 32'd0);
    drv_man = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while SEND.
    sq[3].push_back(9'h155);
    begin
      int k;
      k = 0;
      while (tx_start !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) check("t5_start_timeout", 32'(k), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("t5");
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_idle();

`ifdef UART_ARB_WATCHDOG_EN
    // Transmitter hangs; watchdog aborts, 2 is next.
    hang = 1'b1;
    rc   = abort_cnt;
    base = log_q.size();
    nr   = rise_q.size();
    sq[1].push_back(9'h166);
    sq[2].push_back(9'h177);
    begin
      int k;
      k = 0;
      while (abort_cnt == rc && k < 4 * WDOG + 100) begin
        @(negedge clk);
        k++;
      end
      if (k >= 4 * WDOG + 100)
        check("t6_abort_timeout", 32'(k), 32'd0);
    end
    hang = 1'b0;
    check("t6_abort_time", 32'(abort_cyc - rise_q[nr]), 32'(WDOG));
    check("t6_abort_active", 32'(abort_act), 32'd0);
    wait_log(base + 2);
    wait_idle();
    check("t6_abort_pulses", 32'(abort_cnt - rc), 32'd1);
    check("t6_first", 32'(log_q[base]), 32'h166);
    check("t6_next", 32'(log_q[base + 1]), 32'h277);
`else
    check("abort_quiet", 32'(abort_cnt), 32'd0);
`endif

    check("start_fall_after_done", 32'(fall_err), 32'd0);
    check("tx_data_stable", 32'(data_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
